// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-side bundle for alu_issue_ctrl. The slave modport is the issue
// controller; the master modport is the surrounding decode/ALU/writeback logic.
interface alu_issue_ctrl_if #(
    parameter int unsigned Width = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      instr;
    logic [Width-1:0] rs_data;
    logic [Width-1:0] rt_data;

    logic [Width-1:0] alu_InA;
    logic [Width-1:0] alu_InB;
    logic             alu_Cin;
    logic [3:0]       alu_Oper;
    logic             alu_invA;
    logic             alu_invB;
    logic             alu_sign;
    logic [Width-1:0] alu_Out;
    logic             alu_Zero;
    logic             alu_Ofl;

    logic             res_valid;
    logic             res_ready;
    logic [Width-1:0] res_data;
    logic             res_illegal;
    logic             res_ofl;

    modport master (
        output in_valid, instr, rs_data, rt_data, alu_Out, alu_Zero, alu_Ofl, res_ready,
        input  in_ready, alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign,
        input  res_valid, res_data, res_illegal, res_ofl
    );

    modport slave (
        input  in_valid, instr, rs_data, rt_data, alu_Out, alu_Zero, alu_Ofl, res_ready,
        output in_ready, alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign,
        output res_valid, res_data, res_illegal, res_ofl
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/result pipeline in front of the external WISC ALU.
// Optional macro ALU_OFL_TRAP_EN: registers signed add/sub overflow onto res_ofl.
module alu_issue_ctrl #(
    parameter int unsigned Width = 16
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [3:0] OperAdd = 4'b0100;
    localparam logic [3:0] OperAnd = 4'b0101;
    localparam logic [3:0] OperXor = 4'b0111;

    typedef enum logic [2:0] {
        PostPass, PostSeq, PostSlt, PostSle, PostSco, PostIllegal
    } post_e;

    logic [4:0]       opcode;
    logic [4:0]       imm5;
    logic [1:0]       func;
    logic [Width-1:0] imm_sext;
    logic [Width-1:0] imm_zext;
    logic             unused_instr;

    logic [Width-1:0] ina_d, inb_d;
    logic             cin_d, inva_d, invb_d, sign_d, arith_d;
    logic [3:0]       oper_d;
    post_e            post_d;

    logic             s1_valid_q;
    logic [Width-1:0] ina_q, inb_q;
    logic             cin_q, inva_q, invb_q, sign_q;
    logic [3:0]       oper_q;
    post_e            post_q;

    logic             s2_valid_q;
    logic [Width-1:0] res_data_d, res_data_q;
    logic             res_illegal_d, res_illegal_q;
    logic             less_than;

    logic             accept;
    logic             s2_load;

    assign opcode       = bus.instr[15:11];
    assign imm5         = bus.instr[4:0];
    assign func         = bus.instr[1:0];
    assign imm_sext     = {{(Width-5){imm5[4]}}, imm5};
    assign imm_zext     = {{(Width-5){1'b0}}, imm5};
    assign unused_instr = ^bus.instr[10:5];

    assign s2_load      = s1_valid_q && (!s2_valid_q || bus.res_ready);
    assign bus.in_ready = !s1_valid_q || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        ina_d   = bus.rs_data;
        inb_d   = '0;
        cin_d   = 1'b0;
        oper_d  = '0;
        inva_d  = 1'b0;
        invb_d  = 1'b0;
        sign_d  = 1'b0;
        arith_d = 1'b0;
        post_d  = PostPass;
        case (opcode)
            5'b01000: begin
                inb_d   = imm_sext;
                oper_d  = OperAdd;
                sign_d  = 1'b1;
                arith_d = 1'b1;
            end
            // imm - Rs
            5'b01001: begin
                inb_d   = imm_sext;
                oper_d  = OperAdd;
                inva_d  = 1'b1;
                cin_d   = 1'b1;
                sign_d  = 1'b1;
                arith_d = 1'b1;
            end
            5'b01010: begin
                inb_d  = imm_zext;
                oper_d = OperXor;
            end
            5'b01011: begin
                inb_d  = imm_zext;
                oper_d = OperAnd;
                invb_d = 1'b1;
            end
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                inb_d  = imm_zext;
                oper_d = {2'b00, opcode[1:0]};
            end
            5'b11010: begin
                inb_d  = bus.rt_data;
                oper_d = {2'b00, func};
            end
            5'b11011: begin
                inb_d  = bus.rt_data;
                sign_d = 1'b1;
                case (func)
                    2'b00: begin
                        oper_d  = OperAdd;
                        arith_d = 1'b1;
                    end
                    2'b01: begin
                        oper_d  = OperAdd;
                        inva_d  = 1'b1;
                        cin_d   = 1'b1;
                        arith_d = 1'b1;
                    end
                    2'b10:   oper_d = OperXor;
                    default: begin
                        oper_d = OperAnd;
                        invb_d = 1'b1;
                    end
                endcase
            end
            // Set-conditions compute Rs - Rt and derive the bit afterwards
            5'b11100, 5'b11101, 5'b11110: begin
                inb_d  = bus.rt_data;
                oper_d = OperAdd;
                invb_d = 1'b1;
                cin_d  = 1'b1;
                sign_d = 1'b1;
                case (opcode[1:0])
                    2'b00:   post_d = PostSeq;
                    2'b01:   post_d = PostSlt;
                    default: post_d = PostSle;
                endcase
            end
            5'b11111: begin
                inb_d  = bus.rt_data;
                oper_d = OperAdd;
                post_d = PostSco;
            end
            default: begin
                ina_d  = '0;
                post_d = PostIllegal;
            end
        endcase
    end

    always_comb begin
        less_than     = bus.alu_Out[Width-1] ^ bus.alu_Ofl;
        res_data_d    = bus.alu_Out;
        res_illegal_d = 1'b0;
        case (post_q)
            PostSeq:     res_data_d = {{(Width-1){1'b0}}, bus.alu_Zero};
            PostSlt:     res_data_d = {{(Width-1){1'b0}}, less_than};
            PostSle:     res_data_d = {{(Width-1){1'b0}}, less_than | bus.alu_Zero};
            PostSco:     res_data_d = {{(Width-1){1'b0}}, bus.alu_Ofl};
            PostIllegal: begin
                res_data_d    = '0;
                res_illegal_d = 1'b1;
            end
            default:     res_data_d = bus.alu_Out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            ina_q         <= '0;
            inb_q         <= '0;
            cin_q         <= 1'b0;
            oper_q        <= '0;
            inva_q        <= 1'b0;
            invb_q        <= 1'b0;
            sign_q        <= 1'b0;
            post_q        <= PostPass;
            s2_valid_q    <= 1'b0;
            res_data_q    <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                ina_q      <= ina_d;
                inb_q      <= inb_d;
                cin_q      <= cin_d;
                oper_q     <= oper_d;
                inva_q     <= inva_d;
                invb_q     <= invb_d;
                sign_q     <= sign_d;
                post_q     <= post_d;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_load) begin
                s2_valid_q    <= 1'b1;
                res_data_q    <= res_data_d;
                res_illegal_q <= res_illegal_d;
            end else if (bus.res_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_OFL_TRAP_EN
    logic arith_q;
    logic res_ofl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arith_q   <= 1'b0;
            res_ofl_q <= 1'b0;
        end else begin
            if (accept) begin
                arith_q <= arith_d;
            end
            if (s2_load) begin
                res_ofl_q <= arith_q & bus.alu_Ofl;
            end
        end
    end

    assign bus.res_ofl = res_ofl_q;
`else
    logic unused_arith;
    assign unused_arith = arith_d;
    assign bus.res_ofl  = 1'b0;
`endif

    assign bus.alu_InA     = ina_q;
    assign bus.alu_InB     = inb_q;
    assign bus.alu_Cin     = cin_q;
    assign bus.alu_Oper    = oper_q;
    assign bus.alu_invA    = inva_q;
    assign bus.alu_invB    = invb_q;
    assign bus.alu_sign    = sign_q;
    assign bus.res_valid   = s2_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_illegal = res_illegal_q;
endmodule
